// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin data-memory arbiter between CPU and debug ports
// Adds a debug lock mode with forced release, and routes read responses back to the issuer.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_LOCK     = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_be,
    output logic                cpu_gnt,
    output logic                cpu_rvalid,
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W-1:0]   dbg_wdata,
    input  logic [DATA_W/8-1:0] dbg_be,
    input  logic                dbg_lock,
    output logic                dbg_gnt,
    output logic                dbg_rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                lock_active
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_LOCK) + 1;
    // LOCKED leaves for FORCE on the edge where the counter would reach MAX_LOCK-1
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'((MAX_LOCK > 1) ? (MAX_LOCK - 2) : 0);

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FORCE  = 2'd2
    } state_e;

    state_e                  state_q;
    logic                    last_dbg_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [READ_LATENCY-1:0] cpu_tag_q;
    logic [READ_LATENCY-1:0] dbg_tag_q;

    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_ARB: begin
                    if (cpu_req && dbg_req) begin
                        cpu_gnt = last_dbg_q;
                        dbg_gnt = !last_dbg_q;
                    end else begin
                        cpu_gnt = cpu_req;
                        dbg_gnt = dbg_req;
                    end
                end
                ST_LOCKED: dbg_gnt = dbg_req;
                ST_FORCE:  cpu_gnt = cpu_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_be    = cpu_be;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_be    = dbg_be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARB;
            last_dbg_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (cpu_gnt) begin
                        last_dbg_q <= 1'b0;
                    end else if (dbg_gnt) begin
                        last_dbg_q <= 1'b1;
                    end
                    if (dbg_gnt && dbg_lock) begin
                        state_q <= ST_LOCKED;
                        cnt_q   <= '0;
                    end
                end
                ST_LOCKED: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q >= LOCK_LAST) begin
                        state_q <= ST_FORCE;
                    end else if (!dbg_lock) begin
                        state_q    <= ST_ARB;
                        last_dbg_q <= 1'b1;
                    end
                end
                ST_FORCE: begin
                    if (cpu_gnt) begin
                        last_dbg_q <= 1'b0;
                    end
                    state_q <= ST_ARB;
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

    // One-hot owner tags travel alongside the memory's fixed read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_tag_q <= '0;
            dbg_tag_q <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                cpu_tag_q[i] <= cpu_tag_q[i-1];
                dbg_tag_q[i] <= dbg_tag_q[i-1];
            end
            cpu_tag_q[0] <= cpu_gnt && !cpu_we;
            dbg_tag_q[0] <= dbg_gnt && !dbg_we;
        end
    end

    always_comb begin
        cpu_rvalid  = !rst && cpu_tag_q[READ_LATENCY-1];
        dbg_rvalid  = !rst && dbg_tag_q[READ_LATENCY-1];
        rdata       = (cpu_rvalid || dbg_rvalid) ? mem_rdata : '0;
        lock_active = !rst && (state_q == ST_LOCKED);
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, BE_W[0]};

endmodule
